dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
- Transpose stage between the first (row) and second (column) pass of the 8x8 2D DCT built from the Loeffler 1D core.
- Accepts one 8-coefficient row per beat from the row-pass core and stores eight rows.
- Emits the block column-by-column as 8 sign-extended words per beat, ready for the column-pass core's 16-bit inputs.
- Ping-pong (two-bank) storage: one block fills while the previous block drains.

Parameters:
- IN_W, 12, width of each signed input coefficient (row-pass output width)
- OUT_W, 16, width of each signed output word (column-pass input width); OUT_W >= IN_W
- N, 8, transform size; fixed at 8, other values unsupported

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input row beat valid
- in_ready  output  1  buffer can accept a row this cycle
- in0..in7  input  IN_W each, signed  row coefficients, in0 = coefficient 0
- out_valid  output  1  output column beat valid
- out_ready  input  1  downstream accepts column this cycle
- out0..out7  output  OUT_W each, signed  column words, outK = element from row K
- out_col  output  3  index of column currently presented (0..7)
- out_last  output  1  high with column 7 of a block

Behaviour:
- Storage: bank[2][8 rows][8 cols] of IN_W; full[1:0]; wr_bank, wr_row[2:0]; rd_bank, rd_col[2:0]. Storage is not reset.
- Reset (rst high at edge): full=00, wr_bank=0, wr_row=0, rd_bank=0, rd_col=0. Resulting outputs: in_ready=1, out_valid=0, out_col=0, out_last=0, out0..7=0.
- Reset mid-block discards any partial or unread data. No output appears until 8 new rows have been written.
- Write accept = in_valid && in_ready, where in_ready = !full[wr_bank] (combinational from state only, not from in_valid).
- On write accept: bank[wr_bank][wr_row][k] <= ink for k = 0..7, and wr_row increments.
  - On the accept with wr_row==7: full[wr_bank] <= 1, wr_bank toggles, wr_row wraps to 0.
- out_valid = full[rd_bank]. Read accept = out_valid && out_ready.
- outK = sign-extend(bank[rd_bank][K][rd_col]) to OUT_W when out_valid; 0 when !out_valid. Combinational mux from registered state, so there is no extra pipeline register.
- out_col = rd_col; out_last = out_valid && rd_col==7.
- On read accept: rd_col increments.
  - On the accept with rd_col==7: full[rd_bank] <= 0, rd_bank toggles, rd_col wraps to 0.
- Latency: out_valid rises on the cycle after the edge that accepts row 7 (1 cycle). Column 0 is presented at that point.
- Throughput: 1 row per cycle in, 1 column per cycle out. With out_ready held high, in_ready never drops.
- Backpressure: out_valid, out0..7 and out_col hold stable while out_valid && !out_ready.
- Both banks full: in_ready=0. in_valid is ignored and no state changes on the write side.
- Simultaneous events:
  - Write completing bank A and read completing bank B in the same cycle: both full bits update independently (A set, B clear). Full bits use per-bit set/clear, never a shared read-modify-write.
  - The final read of a bank and the first write into that same bank cannot occur in one cycle. in_ready was 0 for that bank, so the write lands next cycle at the earliest.
- Arithmetic: no math; pure storage and sign extension. The MSB of IN_W is replicated into the upper OUT_W-IN_W bits.

Decomposition:
- Shared package dct_pkg holds:
  - N=8, IN_W=12, OUT_W=16
  - typedef coef_t (signed [IN_W-1:0]), word_t (signed [OUT_W-1:0])
  - typedef row_t (array of 8 coef_t)
  - function sext_coef (coef_t -> word_t)
- One natural sub-module: dct_tp_bank. It is a single 8x8 coef_t register array with a row-write port and a column-read mux, instantiated twice.
- Full flags, pointers and handshake logic stay in the top.

Test Plan:
- Single block: after reset, write rows r=0..7 with ink = 10*r+k, out_ready=1.
  - out_valid rises 1 cycle after row 7.
  - Column c presents outK = 10*K+c for c = 0..7.
  - out_last occurs only with c=7; out_valid drops after 8 beats.
- Sign extension: write row 0 with in0=12'h800 (-2048) and in1=12'h7FF.
  - Column 0 gives out0=16'hF800.
  - Column 1 gives out0=16'h07FF.
- Backpressure: write two blocks (A with value 1, B with value 2) while holding out_ready=0.
  - in_ready drops after 16 rows; a 17th in_valid is ignored.
  - Column 0 of A is held stable for 5 cycles.
  - Release out_ready: A's 8 columns then B's 8 columns stream with no gap, and in_ready returns 1 after A's column 7.
- Streaming: continuous in_valid and out_ready over 4 blocks of random data.
  - in_ready stays 1 throughout.
  - Each output equals the transpose of its input block, in order.
- Reset mid-operation: write 5 rows, assert rst 1 cycle, then write 8 fresh rows.
  - out_valid stays 0 until 1 cycle after the 8th fresh row.
  - The data output is only the fresh block.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types for the 8x8 DCT transpose buffer.
// Coefficient/word widths, row bundle type, sign-extension helper.
package dct_pkg;
  localparam int N     = 8;
  localparam int IN_W  = 12;
  localparam int OUT_W = 16;

  typedef logic signed [IN_W-1:0]  coef_t;
  typedef logic signed [OUT_W-1:0] word_t;
  typedef coef_t [N-1:0]           row_t;

  function automatic word_t sext_coef(coef_t c);
    return {{(OUT_W-IN_W){c[IN_W-1]}}, c};
  endfunction
endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: row-wide write port, column-wide read mux.
// Ports: clk_i, we_i, wr_row_i, row_i (write); rd_col_i, col_o (read).
module dct_tp_bank
  import dct_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [2:0] wr_row_i,
  input  row_t       row_i,
  input  logic [2:0] rd_col_i,
  output row_t       col_o
);

  row_t mem_q [N];

  // Storage is deliberately not reset; full flags gate visibility.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_row_i] <= row_i;
  end

  always_comb begin
    col_o = '0;
    for (int k = 0; k < N; k++) begin
      col_o[k] = mem_q[k][rd_col_i];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between row and column DCT passes.
// Rows in (in0..in7, valid/ready), columns out (out0..out7, valid/ready).
module dct_transpose_buf
  import dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in0,
  input  logic signed [IN_W-1:0]  in1,
  input  logic signed [IN_W-1:0]  in2,
  input  logic signed [IN_W-1:0]  in3,
  input  logic signed [IN_W-1:0]  in4,
  input  logic signed [IN_W-1:0]  in5,
  input  logic signed [IN_W-1:0]  in6,
  input  logic signed [IN_W-1:0]  in7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out0,
  output logic signed [OUT_W-1:0] out1,
  output logic signed [OUT_W-1:0] out2,
  output logic signed [OUT_W-1:0] out3,
  output logic signed [OUT_W-1:0] out4,
  output logic signed [OUT_W-1:0] out5,
  output logic signed [OUT_W-1:0] out6,
  output logic signed [OUT_W-1:0] out7,
  output logic [2:0]              out_col,
  output logic                    out_last
);

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] rd_col_q, rd_col_d;

  logic wr_acc, rd_acc, wr_done, rd_done;
  row_t row_in, col0, col1, col_sel;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready;
  assign wr_done   = wr_acc && (wr_row_q == 3'd7);
  assign rd_done   = rd_acc && (rd_col_q == 3'd7);

  assign row_in = {in7, in6, in5, in4, in3, in2, in1, in0};

  dct_tp_bank u_bank0 (
    .clk_i    (clk),
    .we_i     (wr_acc && !wr_bank_q),
    .wr_row_i (wr_row_q),
    .row_i    (row_in),
    .rd_col_i (rd_col_q),
    .col_o    (col0)
  );

  dct_tp_bank u_bank1 (
    .clk_i    (clk),
    .we_i     (wr_acc && wr_bank_q),
    .wr_row_i (wr_row_q),
    .row_i    (row_in),
    .rd_col_i (rd_col_q),
    .col_o    (col1)
  );

  // Per-bit set/clear: a fill of one bank and a drain of the other
  // in the same cycle must not clobber each other.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (wr_acc) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_acc) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_done) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
    end
  end

  assign col_sel  = rd_bank_q ? col1 : col0;
  assign out_col  = rd_col_q;
  assign out_last = out_valid && (rd_col_q == 3'd7);

  assign out0 = out_valid ? sext_coef(col_sel[0]) : '0;
  assign out1 = out_valid ? sext_coef(col_sel[1]) : '0;
  assign out2 = out_valid ? sext_coef(col_sel[2]) : '0;
  assign out3 = out_valid ? sext_coef(col_sel[3]) : '0;
  assign out4 = out_valid ? sext_coef(col_sel[4]) : '0;
  assign out5 = out_valid ? sext_coef(col_sel[5]) : '0;
  assign out6 = out_valid ? sext_coef(col_sel[6]) : '0;
  assign out7 = out_valid ? sext_coef(col_sel[7]) : '0;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf.
// Table-driven single block plus directed multi-cycle sequences.
module tb_dct_transpose_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [11:0] iv [8];
  logic [15:0] o  [8];
  logic [2:0]  out_col;
  logic        out_last;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] blk [4][8][8];

  always #5 clk = ~clk;

  dct_transpose_buf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (iv[0]),
    .in1       (iv[1]),
    .in2       (iv[2]),
    .in3       (iv[3]),
    .in4       (iv[4]),
    .in5       (iv[5]),
    .in6       (iv[6]),
    .in7       (iv[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (o[0]),
    .out1      (o[1]),
    .out2      (o[2]),
    .out3      (o[3]),
    .out4      (o[4]),
    .out5      (o[5]),
    .out6      (o[6]),
    .out7      (o[7]),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  typedef struct {
    logic       iv;
    logic       ordy;
    int         row;
    logic       ev;
    logic [2:0] ecol;
    logic       elast;
    logic       eir;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int base);
    for (int k = 0; k < 8; k++) iv[k] = 12'(base + k);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) iv[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_col", 16'(out_col), 16'd0);
    chk("rst_out_last", 16'(out_last), 16'd0);
    chk("rst_out0", o[0], 16'd0);

    // ---- single block, table driven ----
    for (int i = 0; i < 17; i++) begin
      tbl[i].iv    = (i < 8);
      tbl[i].ordy  = 1'b1;
      tbl[i].row   = (i < 8) ? i : 0;
      tbl[i].ev    = (i >= 8 && i < 16);
      tbl[i].ecol  = (i >= 8 && i < 16) ? 3'(i - 8) : 3'd0;
      tbl[i].elast = (i == 15);
      tbl[i].eir   = 1'b1;
    end
    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      set_row(10 * tbl[i].row);
      #1;
      chk("blk_in_ready", 16'(in_ready), 16'(tbl[i].eir));
      chk("blk_out_valid", 16'(out_valid), 16'(tbl[i].ev));
      chk("blk_out_last", 16'(out_last), 16'(tbl[i].elast));
      if (tbl[i].ev) begin
        chk("blk_out_col", 16'(out_col), 16'(tbl[i].ecol));
        for (int k = 0; k < 8; k++)
          chk("blk_data", o[k], 16'(10 * k + int'(tbl[i].ecol)));
      end else begin
        chk("blk_idle_out0", o[0], 16'd0);
      end
      step();
    end
    in_valid = 1'b0;

    // ---- sign extension ----
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) iv[k] = '0;
      if (r == 0) begin
        iv[0] = 12'h800;
        iv[1] = 12'h7FF;
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("sx_col0_out0", o[0], 16'hF800);
    chk("sx_col0_out1", o[1], 16'h0000);
    step();
    chk("sx_col1_out0", o[0], 16'h07FF);
    step();
    chk("sx_col2_out0", o[0], 16'h0000);
    repeat (6) step();
    chk("sx_drained", 16'(out_valid), 16'd0);

    // ---- backpressure: two blocks stacked ----
    out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) iv[k] = (r < 8) ? 12'd1 : 12'd2;
      #1;
      chk("bp_in_ready_fill", 16'(in_ready), 16'd1);
      step();
    end
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) iv[k] = 12'd3;
    #1;
    chk("bp_in_ready_full", 16'(in_ready), 16'd0);
    step();
    in_valid = 1'b0;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("bp_hold_valid", 16'(out_valid), 16'd1);
      chk("bp_hold_col", 16'(out_col), 16'd0);
      chk("bp_hold_out0", o[0], 16'd1);
      chk("bp_hold_out7", o[7], 16'd1);
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      #1;
      chk("bp_valid", 16'(out_valid), 16'd1);
      chk("bp_col", 16'(out_col), 16'(j % 8));
      chk("bp_last", 16'(out_last), 16'((j % 8) == 7));
      chk("bp_out3", o[3], (j < 8) ? 16'd1 : 16'd2);
      chk("bp_in_ready", 16'(in_ready), 16'(j >= 8));
      step();
    end
    chk("bp_drained", 16'(out_valid), 16'd0);

    // ---- streaming 4 random blocks ----
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 8; r++)
        for (int k = 0; k < 8; k++)
          blk[b][r][k] = 12'($urandom_range(0, 4095));
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      in_valid = (t < 32);
      if (t < 32)
        for (int k = 0; k < 8; k++) iv[k] = blk[t / 8][t % 8][k];
      #1;
      if (t < 32) chk("st_in_ready", 16'(in_ready), 16'd1);
      if (t >= 8) begin
        chk("st_valid", 16'(out_valid), 16'd1);
        chk("st_col", 16'(out_col), 16'((t - 8) % 8));
        for (int k = 0; k < 8; k++)
          chk("st_data", o[k], sx(blk[(t - 8) / 8][k][(t - 8) % 8]));
      end
      step();
    end
    in_valid = 1'b0;
    chk("st_drained", 16'(out_valid), 16'd0);

    // ---- reset mid-block ----
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) iv[k] = 12'd99;
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mr_valid_after_rst", 16'(out_valid), 16'd0);
    chk("mr_ready_after_rst", 16'(in_ready), 16'd1);
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      set_row(20 * r);
      #1;
      chk("mr_valid_fill", 16'(out_valid), 16'd0);
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("mr_valid", 16'(out_valid), 16'd1);
      chk("mr_col", 16'(out_col), 16'(c));
      for (int k = 0; k < 8; k++)
        chk("mr_data", o[k], 16'(20 * k + c));
      step();
    end
    chk("mr_drained", 16'(out_valid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
